// File: rtl/eth_tx_framer.sv
// eth_tx_framer: byte-wide GMII transmit framer.
// Adds preamble/SFD, zero pad, CRC-32 FCS and IFG; aborts on source underrun.
module eth_tx_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES       = 12,
  parameter int LEN_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic [7:0] gmii_txd_o,
  output logic       gmii_tx_en_o,
  output logic       gmii_tx_er_o,
  output logic       busy_o
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PRE  = 4'd1;
  localparam logic [3:0] S_SFD  = 4'd2;
  localparam logic [3:0] S_PAY  = 4'd3;
  localparam logic [3:0] S_PAD  = 4'd4;
  localparam logic [3:0] S_FCS  = 4'd5;
  localparam logic [3:0] S_ERR  = 4'd6;
  localparam logic [3:0] S_DROP = 4'd7;
  localparam logic [3:0] S_IFG  = 4'd8;

  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [3:0]       state_q, state_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic [31:0]      crc_q, crc_d, crc_nxt;
  logic [7:0]       txd_q, txd_d, crc_in, fcs_byte;
  logic             en_q, en_d, er_q, er_d;
  logic             pad_more;

  function automatic logic [31:0] crc8(input logic [31:0] c,
                                       input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // pad bytes feed zeros into the CRC
  assign crc_in   = (state_q == S_PAY) ? s_data_i : 8'h00;
  assign crc_nxt  = crc8(crc_q, crc_in);
  assign len_inc  = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
  assign pad_more = 32'(len_inc) < 32'(MIN_FRAME_BYTES);

  always_comb begin
    case (tmr_q[1:0])
      2'd0:    fcs_byte = ~crc_q[7:0];
      2'd1:    fcs_byte = ~crc_q[15:8];
      2'd2:    fcs_byte = ~crc_q[23:16];
      default: fcs_byte = ~crc_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    len_d   = len_q;
    crc_d   = crc_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (s_valid_i) begin
          state_d = S_PRE;
          tmr_d   = '0;
          txd_d   = 8'h55;
          en_d    = 1'b1;
        end
      end
      S_PRE: begin
        txd_d = 8'h55;
        en_d  = 1'b1;
        tmr_d = tmr_q + 16'd1;
        if (tmr_q == 16'd5) state_d = S_SFD;
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        en_d    = 1'b1;
        crc_d   = '1;
        len_d   = '0;
        state_d = S_PAY;
      end
      S_PAY: begin
        en_d = 1'b1;
        if (s_valid_i) begin
          txd_d = s_data_i;
          crc_d = crc_nxt;
          len_d = len_inc;
          tmr_d = '0;
          if (s_last_i) state_d = pad_more ? S_PAD : S_FCS;
        end else begin
          er_d    = 1'b1;
          state_d = S_ERR;
        end
      end
      S_PAD: begin
        en_d  = 1'b1;
        crc_d = crc_nxt;
        len_d = len_inc;
        if (!pad_more) state_d = S_FCS;
      end
      S_FCS: begin
        txd_d = fcs_byte;
        en_d  = 1'b1;
        tmr_d = tmr_q + 16'd1;
        if (tmr_q[1:0] == 2'd3) begin
          state_d = S_IFG;
          tmr_d   = '0;
        end
      end
      S_ERR: state_d = S_DROP;
      S_DROP: begin
        if (s_valid_i && s_last_i) begin
          state_d = S_IFG;
          tmr_d   = '0;
        end
      end
      S_IFG: begin
        tmr_d = tmr_q + 16'd1;
        if (tmr_q == IFG_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      len_q   <= '0;
      crc_q   <= '1;
      txd_q   <= 8'h00;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
    end
  end

  assign s_ready_o    = (state_q == S_PAY) || (state_q == S_DROP);
  assign busy_o       = (state_q != S_IDLE);
  assign gmii_txd_o   = txd_q;
  assign gmii_tx_en_o = en_q;
  assign gmii_tx_er_o = er_q;

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Byte-wide 1G Ethernet transmit framer. It is the egress counterpart of the receive parser. It accepts a frame body (destination MAC through end of payload) as a valid/ready/last byte stream and drives a GMII-style transmit interface. On that interface it prepends preamble and SFD, zero-pads short frames, appends the CRC-32 FCS and enforces the inter-frame gap. Mid-frame source underrun is signalled on `gmii_tx_er_o`, and the rest of the frame is discarded.

## Interface
- `MIN_FRAME_BYTES`, default 60: minimum body length before FCS; shorter bodies are padded with 0x00. A value of 0 disables padding.
- `IFG_BYTES`, default 12: minimum `gmii_tx_en_o`-low cycles between frames. Legal range is ≥2.
- `LEN_W`, default 16: width of the body byte counter; it saturates at all-ones.

Ports:
- `clk`  in  1  clock; one byte per cycle.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data_i`  in  8  body byte.
- `s_valid_i`  in  1  body byte valid.
- `s_last_i`  in  1  final body byte; qualified by `s_valid_i && s_ready_o`.
- `s_ready_o`  out  1  byte consumed this cycle when high together with `s_valid_i`.
- `gmii_txd_o`  out  8  transmit byte (registered).
- `gmii_tx_en_o`  out  1  transmit enable (registered).
- `gmii_tx_er_o`  out  1  transmit error (registered).
- `busy_o`  out  1  high in every state except IDLE.

## Operation
States and transitions:
- **IDLE**
  - `s_ready_o`=0.
  - On `s_valid_i`=1 → PREAMBLE. The waiting byte is not consumed.
- **PREAMBLE**
  - 7 cycles of `gmii_txd_o`=0x55, then → SFD.
- **SFD**
  - 1 cycle of 0xD5, then → PAYLOAD.
  - Clears the CRC to 0xFFFFFFFF and the length counter to 0.
- **PAYLOAD**
  - `s_ready_o`=1.
  - Each accepted byte goes to `gmii_txd_o`, updates the CRC and increments the counter.
  - Accepted with `s_last_i`: if the count incl. this byte < `MIN_FRAME_BYTES` → PAD, else → FCS.
  - `s_valid_i`=0 in PAYLOAD is an underrun → ERR.
- **PAD**
  - Emits 0x00 bytes, each included in the CRC, until count = `MIN_FRAME_BYTES`, then → FCS.
  - `s_ready_o`=0.
- **FCS**
  - 4 cycles emitting ~CRC, least-significant byte first, then → IFG.
- **ERR**
  - 1 cycle of `gmii_tx_en_o`=1, `gmii_tx_er_o`=1, `gmii_txd_o`=0x00, then → DROP.
- **DROP**
  - `gmii_tx_en_o`=0, `s_ready_o`=1.
  - Discards bytes through the accepted `s_last_i`, then → IFG.
  - The IFG count starts only after DROP exits.
- **IFG**
  - `gmii_tx_en_o`=0 for the remainder of the gap, then → IDLE.

CRC rules:
- IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-serial, LSB-first.
- Computed over body plus pad bytes only; preamble and SFD are excluded.

Length counter:
- Saturates at 2^LEN_W−1.
- Saturation does not affect framing; it only affects the pad decision.

`gmii_tx_er_o` is asserted only in ERR.

## Timing
- Reset values:
  - `gmii_txd_o`=0x00, `gmii_tx_en_o`=0, `gmii_tx_er_o`=0.
  - `s_ready_o`=0, `busy_o`=0.
  - State is IDLE and CRC is 0xFFFFFFFF.
- Reset mid-frame: on the cycle after `rst` is sampled high, `gmii_tx_en_o`=0 with no `tx_er` pulse. Any partially consumed input is abandoned; the source is responsible for flushing it.
- Start latency: `s_valid_i` first sampled high in IDLE at cycle t gives the first 0x55 on `gmii_txd_o` at t+1. The SFD appears at t+8.
- Data latency: a byte accepted at cycle t appears on `gmii_txd_o` at t+1.
- Frame length: for an N-byte body, `gmii_tx_en_o` is high for exactly 8 + max(N, `MIN_FRAME_BYTES`) + 4 consecutive cycles.
- Back-to-back frames: the gap between FCS byte 4 and the next preamble byte is exactly `IFG_BYTES` cycles with `gmii_tx_en_o`=0. The IDLE cycle is counted in that gap.
- Simultaneous events:
  - `s_last_i` on the byte that reaches `MIN_FRAME_BYTES` → FCS directly, with zero pad bytes.
  - A 1-byte body with `MIN_FRAME_BYTES`=0 goes PAYLOAD → FCS.
- Source arrives during IFG: `s_valid_i` high during IFG is held off (`s_ready_o`=0) with no loss.

## Test plan
- **CRC vector:** `MIN_FRAME_BYTES`=0, body ASCII "123456789" with no stalls.
  - Output: 7×0x55, 0xD5, the 9 bytes, then 0x26 0x39 0xF4 0xCB.
  - `tx_en` high for 21 cycles.
- **Padding:** default params, 14-byte body.
  - 46 bytes of 0x00 are emitted after the body.
  - `tx_en` high for 72 cycles.
  - FCS equals a reference-model CRC over 60 bytes.
  - `s_ready_o` low throughout PAD.
- **Back-to-back:** two 64-byte frames with `s_valid_i` held high.
  - Gap between frames is exactly 12 cycles of `tx_en`=0.
  - No byte lost or duplicated, compared with a scoreboard.
- **Underrun:** drop `s_valid_i` for 3 cycles at body byte 20 of a 100-byte frame.
  - One cycle of `tx_en`=1, `tx_er`=1.
  - `tx_en` stays low while the remaining 80 bytes are drained.
  - Then 12 IFG cycles, after which the next frame is clean.
- **Reset mid-frame:** assert `rst` for one cycle during PAYLOAD byte 30.
  - Next cycle: `tx_en`=0, `tx_er`=0, `busy_o`=0, `s_ready_o`=0.
  - A new frame afterwards is correct with a fresh CRC.
- **Exact-minimum boundary:** 60-byte body.
  - No pad; `tx_en` high for 72 cycles.
  - Repeat with 59 bytes: exactly 1 pad byte, 72 cycles.
